// File: rtl/ndro_pulse_checker.sv
// Observer for a toggle-encoded NDRO stimulus link.
// Tracks the reference stored bit and flags setup, hold, missing-out and spurious-out events.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              1 = raise errors, 0 = only track state/counters
//   ndro_set/reset/clk  toggle-encoded pulse lines into the NDRO
//   ndro_out            toggle-encoded NDRO output line
//   state_o             reference stored bit
//   err_setup/hold/missing/spurious  sticky error flags
//   err_count           saturating total of errors
//   clk_count           ndro_clk events seen, wrapping
module ndro_pulse_checker #(
  parameter int SETUP_CYC   = 4,
  parameter int HOLD_CYC    = 4,
  parameter int OUT_MAX_LAT = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ndro_set,
  input  logic             ndro_reset,
  input  logic             ndro_clk,
  input  logic             ndro_out,
  output logic             state_o,
  output logic             err_setup,
  output logic             err_hold,
  output logic             err_missing,
  output logic             err_spurious,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] clk_count
);

  localparam int SD_W = $clog2(SETUP_CYC + 1);
  localparam int SC_W = $clog2(HOLD_CYC + 1);
  localparam int LT_W = $clog2(OUT_MAX_LAT + 1);

  localparam logic [SD_W-1:0] SD_MAX = SD_W'(SETUP_CYC);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(HOLD_CYC);
  localparam logic [LT_W-1:0] LT_MAX = LT_W'(OUT_MAX_LAT);

  logic r_s1_set, r_s1_rst, r_s1_clk, r_s1_out;
  logic r_s2_set, r_s2_rst, r_s2_clk, r_s2_out;

  logic            r_state;
  logic [SD_W-1:0] r_since_data;
  logic [SC_W-1:0] r_since_clk;
  logic            r_clk_seen;
  logic            r_armed;
  logic [LT_W-1:0] r_lat;

  logic             r_err_setup;
  logic             r_err_hold;
  logic             r_err_missing;
  logic             r_err_spurious;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_clk_count;

  logic w_e_set, w_e_rst, w_e_clk, w_e_out;
  logic w_data;
  logic w_setup, w_hold, w_miss, w_spur;
  logic w_armed_nx;
  logic [LT_W-1:0] w_lat_nx;
  logic [2:0] w_nerr;
  logic [CNT_W:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nx;

  assign w_e_set = r_s1_set ^ r_s2_set;
  assign w_e_rst = r_s1_rst ^ r_s2_rst;
  assign w_e_clk = r_s1_clk ^ r_s2_clk;
  assign w_e_out = r_s1_out ^ r_s2_out;
  assign w_data  = w_e_set | w_e_rst;

  // A set/reset conflict is a setup error even without a clock event.
  assign w_setup = enable &
    ((w_e_clk & ((r_since_data < SD_MAX) | w_data)) |
     (w_e_set & w_e_rst));

  // Same-cycle clk+data is already a setup error; not a hold error.
  assign w_hold = enable & w_data & ~w_e_clk &
                  r_clk_seen & (r_since_clk < SC_MAX);

  // Output window: arm on a clock event while the stored bit is 1.
  // An e_out arriving with the arming clock event belongs to the old window.
  always_comb begin
    w_armed_nx = r_armed;
    w_lat_nx   = r_lat;
    w_miss     = 1'b0;
    w_spur     = 1'b0;
    if (!enable) begin
      w_armed_nx = 1'b0;
    end else if (w_e_clk && r_state) begin
      w_miss     = r_armed & ~w_e_out;
      w_spur     = ~r_armed & w_e_out;
      w_armed_nx = 1'b1;
      w_lat_nx   = LT_MAX;
    end else if (w_e_out) begin
      w_spur     = ~r_armed;
      w_armed_nx = 1'b0;
    end else if (r_armed) begin
      if (r_lat == '0) begin
        w_miss     = 1'b1;
        w_armed_nx = 1'b0;
      end else begin
        w_lat_nx = r_lat - 1'b1;
      end
    end
  end

  assign w_nerr = 3'(w_setup) + 3'(w_hold) +
                  3'(w_miss) + 3'(w_spur);
  assign w_sum  = {1'b0, r_err_count} + (CNT_W+1)'(w_nerr);
  assign w_cnt_nx = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_set       <= 1'b0;
      r_s1_rst       <= 1'b0;
      r_s1_clk       <= 1'b0;
      r_s1_out       <= 1'b0;
      r_s2_set       <= 1'b0;
      r_s2_rst       <= 1'b0;
      r_s2_clk       <= 1'b0;
      r_s2_out       <= 1'b0;
      r_state        <= 1'b0;
      r_since_data   <= SD_MAX;
      r_since_clk    <= SC_MAX;
      r_clk_seen     <= 1'b0;
      r_armed        <= 1'b0;
      r_lat          <= '0;
      r_err_setup    <= 1'b0;
      r_err_hold     <= 1'b0;
      r_err_missing  <= 1'b0;
      r_err_spurious <= 1'b0;
      r_err_count    <= '0;
      r_clk_count    <= '0;
    end else begin
      r_s1_set <= ndro_set;
      r_s1_rst <= ndro_reset;
      r_s1_clk <= ndro_clk;
      r_s1_out <= ndro_out;
      r_s2_set <= r_s1_set;
      r_s2_rst <= r_s1_rst;
      r_s2_clk <= r_s1_clk;
      r_s2_out <= r_s1_out;

      if (w_e_set && !w_e_rst) begin
        r_state <= 1'b1;
      end else if (w_e_rst && !w_e_set) begin
        r_state <= 1'b0;
      end

      if (w_data) begin
        r_since_data <= '0;
      end else if (r_since_data < SD_MAX) begin
        r_since_data <= r_since_data + 1'b1;
      end

      if (w_e_clk) begin
        r_since_clk <= '0;
        r_clk_seen  <= 1'b1;
        r_clk_count <= r_clk_count + 1'b1;
      end else if (r_since_clk < SC_MAX) begin
        r_since_clk <= r_since_clk + 1'b1;
      end

      r_armed <= w_armed_nx;
      r_lat   <= w_lat_nx;

      if (w_setup) r_err_setup    <= 1'b1;
      if (w_hold)  r_err_hold     <= 1'b1;
      if (w_miss)  r_err_missing  <= 1'b1;
      if (w_spur)  r_err_spurious <= 1'b1;
      r_err_count <= w_cnt_nx;
    end
  end

  assign state_o      = r_state;
  assign err_setup    = r_err_setup;
  assign err_hold     = r_err_hold;
  assign err_missing  = r_err_missing;
  assign err_spurious = r_err_spurious;
  assign err_count    = r_err_count;
  assign clk_count    = r_clk_count;

endmodule

// File: tb/tb_ndro_pulse_checker.sv
// Bench for ndro_pulse_checker.
// Timestamp-based reference model, directed scenarios and randomized toggles.
module tb_ndro_pulse_checker;

  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int LAT   = 8;
  localparam int CW    = 8;
  localparam int NEVER = -1000;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic ndro_set;
  logic ndro_reset;
  logic ndro_clk;
  logic ndro_out;
  logic state_o;
  logic err_setup;
  logic err_hold;
  logic err_missing;
  logic err_spurious;
  logic [CW-1:0] err_count;
  logic [CW-1:0] clk_count;

  int n_checks = 0;
  int n_fail   = 0;

  ndro_pulse_checker #(
    .SETUP_CYC  (SETUP),
    .HOLD_CYC   (HOLD),
    .OUT_MAX_LAT(LAT),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ndro_set    (ndro_set),
    .ndro_reset  (ndro_reset),
    .ndro_clk    (ndro_clk),
    .ndro_out    (ndro_out),
    .state_o     (state_o),
    .err_setup   (err_setup),
    .err_hold    (err_hold),
    .err_missing (err_missing),
    .err_spurious(err_spurious),
    .err_count   (err_count),
    .clk_count   (clk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d",
               name, $time, act, exp);
    end
  endtask

  // Reference model: events are timestamped by edge number.
  int m_edge = 0;
  bit [3:0] m_lvl;
  bit [3:0] m_pend;
  bit m_state, m_es, m_eh, m_em, m_esp;
  int m_cnt, m_clkc;
  int last_data, last_clk, arm_edge;
  bit clk_seen, armed;

  task automatic model_clear();
    m_lvl = '0; m_pend = '0;
    m_state = 0; m_es = 0; m_eh = 0; m_em = 0; m_esp = 0;
    m_cnt = 0; m_clkc = 0;
    last_data = NEVER; last_clk = NEVER; arm_edge = NEVER;
    clk_seen = 0; armed = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      m_edge++;
      if (reset) begin
        model_clear();
      end else begin
        bit [3:0] ev;
        bit [3:0] now;
        bit evs, evr, evc, evo, data;
        bit es, eh, em, esp;
        now = {ndro_out, ndro_clk, ndro_reset, ndro_set};
        ev = m_pend;
        m_pend = now ^ m_lvl;
        m_lvl = now;
        evs = ev[0]; evr = ev[1]; evc = ev[2]; evo = ev[3];
        data = evs | evr;
        es = 0; eh = 0; em = 0; esp = 0;
        if (enable) begin
          if ((evc && (m_edge - last_data <= SETUP || data)) ||
              (evs && evr))
            es = 1;
          if (data && !evc && clk_seen &&
              m_edge - last_clk <= HOLD)
            eh = 1;
          if (evc && m_state) begin
            if (armed && !evo) em = 1;
            if (!armed && evo) esp = 1;
            armed = 1;
            arm_edge = m_edge;
          end else if (evo) begin
            if (!armed) esp = 1;
            armed = 0;
          end else if (armed && m_edge - arm_edge > LAT) begin
            em = 1;
            armed = 0;
          end
        end else begin
          armed = 0;
        end
        if (evs && !evr) m_state = 1;
        if (evr && !evs) m_state = 0;
        if (data) last_data = m_edge;
        if (evc) begin
          last_clk = m_edge;
          clk_seen = 1;
          m_clkc = (m_clkc + 1) % (1 << CW);
        end
        m_es  |= es;
        m_eh  |= eh;
        m_em  |= em;
        m_esp |= esp;
        m_cnt += int'(es) + int'(eh) + int'(em) + int'(esp);
        if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("state",    int'(state_o),      int'(m_state));
      chk("setup",    int'(err_setup),    int'(m_es));
      chk("hold",     int'(err_hold),     int'(m_eh));
      chk("missing",  int'(err_missing),  int'(m_em));
      chk("spurious", int'(err_spurious), int'(m_esp));
      chk("errcnt",   int'(err_count),    m_cnt);
      chk("clkcnt",   int'(clk_count),    m_clkc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic zero_lines();
    ndro_set = 0; ndro_reset = 0;
    ndro_clk = 0; ndro_out = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    zero_lines();
    cyc(2);
    reset = 0;
  endtask

  initial begin
    int out_due;
    reset = 1;
    enable = 1;
    zero_lines();
    cyc(2);
    chk("rst_state", int'(state_o), 0);
    chk("rst_cnt", int'(err_count), 0);
    reset = 0;

    // 1: clean set / clk / out
    ndro_set = ~ndro_set; cyc(10);
    ndro_clk = ~ndro_clk; cyc(3);
    ndro_out = ~ndro_out; cyc(4);
    chk("t1_state", int'(state_o), 1);
    chk("t1_errcnt", int'(err_count), 0);
    chk("t1_clkcnt", int'(clk_count), 1);

    // 2: reset too soon after clk
    ndro_clk = ~ndro_clk; cyc(2);
    ndro_reset = ~ndro_reset; cyc(3);
    chk("t2_hold", int'(err_hold), 1);
    chk("t2_errcnt", int'(err_count), 1);
    chk("t2_state", int'(state_o), 0);
    ndro_out = ~ndro_out; cyc(3);
    chk("t2_missing", int'(err_missing), 0);
    do_reset();

    // 3: clk too soon after reset
    ndro_reset = ~ndro_reset; cyc(2);
    ndro_clk = ~ndro_clk; cyc(12);
    chk("t3_setup", int'(err_setup), 1);
    chk("t3_missing", int'(err_missing), 0);
    chk("t3_errcnt", int'(err_count), 1);
    do_reset();

    // 4: missing out, exact timing
    ndro_set = ~ndro_set; cyc(10);
    ndro_clk = ~ndro_clk; cyc(10);
    chk("t4_early", int'(err_missing), 0);
    cyc(1);
    chk("t4_missing", int'(err_missing), 1);
    chk("t4_errcnt", int'(err_count), 1);
    do_reset();

    // 5: spurious out, set/reset conflict
    ndro_out = ~ndro_out; cyc(3);
    ndro_set = ~ndro_set;
    ndro_reset = ~ndro_reset; cyc(3);
    chk("t5_spur", int'(err_spurious), 1);
    chk("t5_setup", int'(err_setup), 1);
    chk("t5_state", int'(state_o), 0);
    chk("t5_errcnt", int'(err_count), 2);
    do_reset();

    // 6: saturation, then reset mid-window
    repeat (300) begin
      ndro_out = ~ndro_out; cyc(1);
    end
    cyc(2);
    chk("t6_sat", int'(err_count), 255);
    ndro_set = ~ndro_set; cyc(10);
    ndro_clk = ~ndro_clk; cyc(4);
    reset = 1; cyc(1);
    chk("t6_state", int'(state_o), 0);
    chk("t6_flags", int'({err_setup, err_hold,
                          err_missing, err_spurious}), 0);
    chk("t6_errcnt", int'(err_count), 0);
    chk("t6_clkcnt", int'(clk_count), 0);
    zero_lines(); cyc(1);
    reset = 0; cyc(12);
    chk("t6_nomiss", int'(err_missing), 0);

    // Randomized toggles
    out_due = -1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        if ($urandom_range(0, 1) == 1) zero_lines();
        cyc(2);
        reset = 0;
      end
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 99) < 5) ndro_set = ~ndro_set;
      if ($urandom_range(0, 99) < 5) ndro_reset = ~ndro_reset;
      if ($urandom_range(0, 99) < 8) begin
        ndro_clk = ~ndro_clk;
        if ($urandom_range(0, 3) != 0)
          out_due = i + int'($urandom_range(1, 10));
      end
      if (i == out_due || $urandom_range(0, 99) < 3)
        ndro_out = ~ndro_out;
      cyc(1);
    end

    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
